// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial-product step per clock, WIDTH-cycle latency.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port and two's-complement operation.
module seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = 2 * WIDTH + 1;
    localparam int unsigned UW = WIDTH + 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_last;

    logic [WIDTH-1:0] r_mcand;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [PW-1:0]    r_p;

    logic [UW-1:0]    w_upper;
    logic [UW-1:0]    w_ext;
    logic [UW-1:0]    w_sum;
    logic             w_fill;
    logic [AW-1:0]    w_acc_step;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_RUN;
                    w_accept = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next   = S_RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One step: conditional add (or final-step subtract) into the upper half, then shift right.
    assign w_upper = r_acc[AW-1:WIDTH];

`ifdef SEQ_MULT_SIGNED_EN
    logic r_signed;

    always_comb begin
        w_ext  = {r_signed & r_mcand[WIDTH-1], r_mcand};
        w_sum  = w_upper;
        if (r_acc[0]) begin
            if (r_signed && w_last) begin
                w_sum = w_upper - w_ext;
            end else begin
                w_sum = w_upper + w_ext;
            end
        end
        w_fill = r_signed & w_sum[UW-1];
    end
`else
    always_comb begin
        w_ext  = {1'b0, r_mcand};
        w_sum  = r_acc[0] ? (w_upper + w_ext) : w_upper;
        w_fill = 1'b0;
    end
`endif

    assign w_acc_step = {w_fill, w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
            if (w_accept) begin
                r_mcand <= A;
                r_acc   <= {UW'(0), B};
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_p <= w_acc_step[PW-1:0];
                end
            end
        end
    end

`ifdef SEQ_MULT_SIGNED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_signed <= signed_mode;
        end
    end
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult: an 8-bit and a 4-bit instance share clock and reset.
module tb_seq_mult;

    logic        clk;
    logic        reset;

    logic        s8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        s4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    int total;
    int bad;

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .start       (s8),
        .A           (a8),
        .B           (b8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (sm8),
`endif
        .busy        (busy8),
        .done        (done8),
        .P           (p8)
    );

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .start       (s4),
        .A           (a4),
        .B           (b4),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (sm4),
`endif
        .busy        (busy4),
        .done        (done4),
        .P           (p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse; returns at the negedge just after the accept edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        @(negedge clk);
        a8 = a; b8 = b; sm8 = sm; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    // Count cycles from the accept edge to done; cyc stays 40 on timeout.
    task automatic wait8(output int cyc, output int busy_n, output int both);
        cyc = 0; busy_n = busy8 ? 1 : 0; both = 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) busy_n++;
            if (busy8 && done8) both++;
        end
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        a4 = a; b4 = b; sm4 = 1'b0; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
    endtask

    task automatic wait4(output int cyc);
        cyc = 0;
        while (!done4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total += 6;
        if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        if (p8 !== 16'h0)   begin bad++; $display("FAIL reset_p8 got=%h exp=0000", p8); end
        if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
        if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done4 got=%b exp=0", done4); end
        if (p4 !== 8'h0)    begin bad++; $display("FAIL reset_p4 got=%h exp=00", p4); end
        reset = 1'b0;
    endtask

    task automatic test_unsigned_max;
        int cyc, bn, both;
        go8(8'd255, 8'd255, 1'b0);
        a8 = 8'h00; b8 = 8'h00;
        wait8(cyc, bn, both);
        total += 5;
        if (p8 !== 16'hFE01) begin bad++; $display("FAIL max_p got=%h exp=fe01", p8); end
        if (cyc != 8)        begin bad++; $display("FAIL max_latency got=%0d exp=8", cyc); end
        if (bn != 8)         begin bad++; $display("FAIL max_busy_cycles got=%0d exp=8", bn); end
        if (both != 0)       begin bad++; $display("FAIL max_busy_and_done got=%0d exp=0", both); end
        @(negedge clk);
        if (done8 !== 1'b0 || p8 !== 16'hFE01) begin
            bad++; $display("FAIL max_pulse_hold done=%b p=%h exp done=0 p=fe01", done8, p8);
        end
    endtask

    task automatic test_zero_one;
        int cyc, pulses;
        go4(4'd13, 4'd0);
        wait4(cyc);
        total += 2;
        if (p4 !== 8'd0) begin bad++; $display("FAIL zero_p got=%0d exp=0", p4); end
        if (cyc != 4)    begin bad++; $display("FAIL zero_latency got=%0d exp=4", cyc); end
        go4(4'd13, 4'd1);
        wait4(cyc);
        total += 2;
        if (p4 !== 8'd13) begin bad++; $display("FAIL one_p got=%0d exp=13", p4); end
        if (cyc != 4)     begin bad++; $display("FAIL one_latency got=%0d exp=4", cyc); end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done4) pulses++;
        end
        total += 1;
        if (pulses != 0) begin bad++; $display("FAIL one_extra_done got=%0d exp=0", pulses); end
    endtask

    task automatic test_busy_reject;
        int cyc, bn, both, pulses;
        go8(8'd7, 8'd9, 1'b0);
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd3; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        wait8(cyc, bn, both);
        total += 2;
        if (p8 !== 16'd63) begin bad++; $display("FAIL reject_p got=%0d exp=63", p8); end
        if (cyc != 6)      begin bad++; $display("FAIL reject_latency got=%0d exp=6", cyc); end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        total += 2;
        if (pulses != 0)   begin bad++; $display("FAIL reject_second_op got=%0d exp=0", pulses); end
        if (p8 !== 16'd63) begin bad++; $display("FAIL reject_p_hold got=%0d exp=63", p8); end
    endtask

    task automatic test_back_to_back;
        int cyc, bn, both;
        go8(8'd10, 8'd10, 1'b0);
        wait8(cyc, bn, both);
        a8 = 8'd2; b8 = 8'd3; s8 = 1'b1;
        total += 2;
        if (p8 !== 16'h0064 || done8 !== 1'b1) begin
            bad++; $display("FAIL b2b_first got p=%h done=%b exp p=0064 done=1", p8, done8);
        end
        if (cyc != 8) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=8", cyc); end
        @(negedge clk);
        s8 = 1'b0;
        total += 1;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            bad++; $display("FAIL b2b_reaccept busy=%b done=%b exp busy=1 done=0", busy8, done8);
        end
        wait8(cyc, bn, both);
        total += 2;
        if (p8 !== 16'h0006) begin bad++; $display("FAIL b2b_second_p got=%h exp=0006", p8); end
        if (cyc != 8)        begin bad++; $display("FAIL b2b_second_latency got=%0d exp=8", cyc); end
    endtask

    task automatic test_reset_mid;
        int cyc, bn, both;
        go8(8'd200, 8'd100, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        total += 3;
        if (busy8 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
        if (done8 !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done8); end
        if (p8 !== 16'h0)   begin bad++; $display("FAIL midrst_p got=%h exp=0000", p8); end
        @(negedge clk);
        reset = 1'b0;
        go8(8'd5, 8'd6, 1'b0);
        wait8(cyc, bn, both);
        total += 2;
        if (p8 !== 16'd30) begin bad++; $display("FAIL midrst_fresh_p got=%0d exp=30", p8); end
        if (cyc != 8)      begin bad++; $display("FAIL midrst_fresh_latency got=%0d exp=8", cyc); end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed;
        int cyc, bn, both;
        logic [7:0]  va [5];
        logic [7:0]  vb [5];
        logic        vs [5];
        logic [15:0] vp [5];
        va = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'hFF};
        vb = '{8'h80, 8'h01, 8'h80, 8'h80, 8'h01};
        vs = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        vp = '{16'h4000, 16'hFFFF, 16'hC080, 16'h4000, 16'h00FF};
        for (int i = 0; i < 5; i++) begin
            go8(va[i], vb[i], vs[i]);
            wait8(cyc, bn, both);
            total += 2;
            if (p8 !== vp[i]) begin
                bad++; $display("FAIL signed_p[%0d] got=%h exp=%h", i, p8, vp[i]);
            end
            if (cyc != 8) begin
                bad++; $display("FAIL signed_latency[%0d] got=%0d exp=8", i, cyc);
            end
        end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        s8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        s4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        reset = 1'b1;
        test_reset;
        test_unsigned_max;
        test_zero_one;
        test_busy_reject;
        test_back_to_back;
        test_reset_mid;
`ifdef SEQ_MULT_SIGNED_EN
        test_signed;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
